// File: rtl/icache_refill_unit.sv
// icache_refill_unit: handles an instruction-cache line miss.
// For each miss it issues one 4-beat burst read, assembles the beats into a
// 128-bit line, writes that line and its tag in a single cycle, and returns
// the requested (critical) word to the fetch stage.
// Ports:
//   clk, reset                       clock, async active-high reset
//   miss_valid/miss_addr/miss_ready  miss request from the front end (ready only in IDLE)
//   rsp_valid/rsp_data/rsp_err       one-cycle completion pulse, critical word, error flag
//   rd_req_*                         burst read request (line-aligned address, len=3)
//   rd_data_valid/rd_data/last       returned read beats
//   ram_addr/ram_strobe/ram_wdata    data array line write
//   tag_we/tag_index/tag_value       tag array update
module icache_refill_unit #(
    parameter  int unsigned INDEX_BITS  = 6,
    localparam int unsigned OFFSET_BITS = 4,
    localparam int unsigned TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss_valid,
    input  logic [31:0]           miss_addr,
    output logic                  miss_ready,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    output logic                  rd_req_valid,
    output logic [31:0]           rd_req_addr,
    output logic [7:0]            rd_req_len,
    input  logic                  rd_req_ready,
    input  logic                  rd_data_valid,
    input  logic [31:0]           rd_data,
    input  logic                  rd_data_last,
    output logic [INDEX_BITS-1:0] ram_addr,
    output logic [15:0]           ram_strobe,
    output logic [127:0]          ram_wdata,
    output logic                  tag_we,
    output logic [INDEX_BITS-1:0] tag_index,
    output logic [TAG_BITS-1:0]   tag_value
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_FILL  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [31:2]    r_addr;     // byte-in-word bits are never needed
    logic [127:0]   r_line;
    logic [1:0]     r_cnt;
    logic [31:0]    r_crit;
    logic           r_err;
    logic           r_drain;    // overlong burst: swallow beats until last

    logic           w_miss_ready;
    logic           w_rd_req_valid;
    logic [15:0]    w_ram_strobe;
    logic           w_tag_we;
    logic           w_rsp_valid;
    logic           w_unused_lsb;

    assign w_unused_lsb = ^miss_addr[1:0];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (miss_valid) w_next = S_REQ;
            S_REQ:   if (rd_req_ready) w_next = S_FILL;
            S_FILL: begin
                // A full, well-formed burst ends exactly on beat 3 with last
                if (rd_data_valid && rd_data_last) begin
                    w_next = (r_drain || (r_cnt != 2'd3)) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode (Moore, from the state register)
    always_comb begin
        w_miss_ready   = 1'b0;
        w_rd_req_valid = 1'b0;
        w_ram_strobe   = 16'h0000;
        w_tag_we       = 1'b0;
        w_rsp_valid    = 1'b0;
        unique case (r_state)
            S_IDLE:  w_miss_ready = 1'b1;
            S_REQ:   w_rd_req_valid = 1'b1;
            S_FILL:  ;
            S_WRITE: begin
                w_ram_strobe = 16'hFFFF;
                w_tag_we     = 1'b1;
            end
            S_DONE:  w_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Miss capture and line assembly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_line  <= '0;
            r_cnt   <= 2'd0;
            r_crit  <= 32'd0;
            r_err   <= 1'b0;
            r_drain <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (miss_valid) begin
                        r_addr  <= miss_addr[31:2];
                        r_line  <= '0;
                        r_cnt   <= 2'd0;
                        r_err   <= 1'b0;
                        r_drain <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (rd_data_valid && !r_drain) begin
                        r_line[{r_cnt, 5'd0} +: 32] <= rd_data;
                        if (r_cnt == r_addr[3:2]) begin
                            r_crit <= rd_data;
                        end
                        if (rd_data_last) begin
                            if (r_cnt != 2'd3) begin
                                r_err <= 1'b1;
                            end
                        end else if (r_cnt == 2'd3) begin
                            r_err   <= 1'b1;
                            r_drain <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign miss_ready   = w_miss_ready;
    assign rd_req_valid = w_rd_req_valid;
    assign rd_req_addr  = {r_addr[31:OFFSET_BITS], OFFSET_BITS'(0)};
    assign rd_req_len   = 8'd3;
    assign rsp_valid    = w_rsp_valid;
    assign rsp_data     = r_crit;
    assign rsp_err      = w_rsp_valid & r_err;
    assign ram_addr     = r_addr[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
    assign ram_strobe   = w_ram_strobe;
    assign ram_wdata    = r_line;
    assign tag_we       = w_tag_we;
    assign tag_index    = r_addr[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
    assign tag_value    = r_addr[31:INDEX_BITS+OFFSET_BITS];

endmodule

// File: tb/tb_icache_refill_unit.sv
// Self-checking bench for icache_refill_unit: a table of miss scenarios is
// applied in a loop; expected writes/responses are queued when stimulus is
// driven and compared by a monitor when the DUT produces them.
module tb_icache_refill_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic         miss_valid;
    logic [31:0]  miss_addr;
    logic         miss_ready;
    logic         rsp_valid;
    logic [31:0]  rsp_data;
    logic         rsp_err;
    logic         rd_req_valid;
    logic [31:0]  rd_req_addr;
    logic [7:0]   rd_req_len;
    logic         rd_req_ready;
    logic         rd_data_valid;
    logic [31:0]  rd_data;
    logic         rd_data_last;
    logic [5:0]   ram_addr;
    logic [15:0]  ram_strobe;
    logic [127:0] ram_wdata;
    logic         tag_we;
    logic [5:0]   tag_index;
    logic [21:0]  tag_value;

    icache_refill_unit #(.INDEX_BITS(6)) dut (
        .clk(clk), .reset(reset),
        .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
        .rd_req_ready(rd_req_ready),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_data_last(rd_data_last),
        .ram_addr(ram_addr), .ram_strobe(ram_strobe), .ram_wdata(ram_wdata),
        .tag_we(tag_we), .tag_index(tag_index), .tag_value(tag_value)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]       addr;
        logic [31:0]       base;   // beat i carries base+i
        int unsigned       nb;     // beats in the burst, last on nb-1
        int unsigned       stall;  // cycles rd_req_ready held low
        int unsigned       gap;    // idle cycles between beats
        logic              wr;
        logic              err;
        logic [31:0]       crit;
        logic [5:0]        idx;
    } vec_t;

    typedef struct packed {
        logic [5:0]   idx;
        logic [127:0] line;
        logic [21:0]  tag;
    } wr_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    wr_t  exp_wr[$];
    rsp_t exp_rsp[$];
    vec_t vecs[7];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int acc_cyc;
    bit busy   = 1'b0;
    bit glitch = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (busy && miss_ready) glitch = 1'b1;
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] base,
                                input int unsigned nb, input int unsigned stall,
                                input int unsigned gap, input logic wr, input logic err,
                                input logic [31:0] crit, input logic [5:0] idx);
        vec_t v;
        v.addr = addr; v.base = base; v.nb = nb; v.stall = stall; v.gap = gap;
        v.wr = wr; v.err = err; v.crit = crit; v.idx = idx;
        return v;
    endfunction

    // Monitor: compare line writes and responses against the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (ram_strobe != 16'h0 || tag_we) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 128'(ram_strobe), 128'(0));
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("wr_strobe", 128'(ram_strobe), 128'(16'hFFFF));
                    chk("wr_tag_we", 128'(tag_we), 128'(1'b1));
                    chk("wr_ram_addr", 128'(ram_addr), 128'(w.idx));
                    chk("wr_tag_index", 128'(tag_index), 128'(w.idx));
                    chk("wr_line", ram_wdata, w.line);
                    chk("wr_tag_value", 128'(tag_value), 128'(w.tag));
                end
            end
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rsp", 128'(rsp_valid), 128'(0));
                end else begin
                    rsp_t r;
                    r = exp_rsp.pop_front();
                    chk("rsp_data", 128'(rsp_data), 128'(r.data));
                    chk("rsp_err", 128'(rsp_err), 128'(r.err));
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_miss_ready"}, 128'(miss_ready), 128'(1'b1));
        chk({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
        chk({tag, "_rsp_err"}, 128'(rsp_err), 128'(0));
        chk({tag, "_rsp_data"}, 128'(rsp_data), 128'(0));
        chk({tag, "_req_valid"}, 128'(rd_req_valid), 128'(0));
        chk({tag, "_req_addr"}, 128'(rd_req_addr), 128'(0));
        chk({tag, "_strobe"}, 128'(ram_strobe), 128'(0));
        chk({tag, "_tag_we"}, 128'(tag_we), 128'(0));
        chk({tag, "_wdata"}, ram_wdata, 128'(0));
        chk({tag, "_ram_addr"}, 128'(ram_addr), 128'(0));
        chk({tag, "_tag_value"}, 128'(tag_value), 128'(0));
    endtask

    task automatic run_vec(input vec_t v);
        logic [127:0] line;
        int unsigned  lat_exp;
        bit           seen;
        line = '0;
        for (int i = 0; i < 4; i++)
            if (i < int'(v.nb)) line[i*32 +: 32] = v.base + 32'(i);
        lat_exp = (v.wr ? 3 : 2) + v.stall + (v.nb - 1) * (v.gap + 1);
        if (v.wr) exp_wr.push_back('{idx: v.idx, line: line, tag: v.addr[31:10]});
        exp_rsp.push_back('{data: v.crit, err: v.err});

        miss_addr  = v.addr;
        miss_valid = 1'b1;
        tick();
        acc_cyc    = cyc;
        miss_valid = 1'b0;
        miss_addr  = 32'hFFFF_FFFF;   // latched copy must be used from here on
        busy       = 1'b1;
        glitch     = 1'b0;

        for (int s = 0; s <= int'(v.stall); s++) begin
            chk("req_valid", 128'(rd_req_valid), 128'(1'b1));
            chk("req_addr", 128'(rd_req_addr), 128'({v.addr[31:4], 4'h0}));
            chk("req_len", 128'(rd_req_len), 128'(8'd3));
            rd_req_ready = (s == int'(v.stall));
            tick();
        end
        rd_req_ready = 1'b0;
        chk("req_drop", 128'(rd_req_valid), 128'(0));

        for (int b = 0; b < int'(v.nb); b++) begin
            rd_data_valid = 1'b1;
            rd_data       = v.base + 32'(b);
            rd_data_last  = (b == int'(v.nb) - 1);
            tick();
            rd_data_valid = 1'b0;
            rd_data_last  = 1'b0;
            rd_data       = 32'h5A5A_5A5A;
            if (b != int'(v.nb) - 1)
                for (int g = 0; g < int'(v.gap); g++) tick();
        end

        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("rsp_seen", 128'(seen), 128'(1'b1));
        chk("rsp_latency", 128'(cyc - acc_cyc), 128'(lat_exp));
        chk("line_hold", ram_wdata, line);
        busy = 1'b0;
        chk("busy_ready_low", 128'(glitch), 128'(0));
        tick();
        chk("ready_after_done", 128'(miss_ready), 128'(1'b1));
        chk("rsp_pulse_1cyc", 128'(rsp_valid), 128'(0));
        chk("wr_queue_empty", 128'(exp_wr.size()), 128'(0));
        chk("rsp_queue_empty", 128'(exp_rsp.size()), 128'(0));
    endtask

    // Reset asserted in the middle of FILL, after two beats
    task automatic reset_mid_fill();
        miss_addr  = 32'h0000_0500;
        miss_valid = 1'b1;
        tick();
        miss_valid = 1'b0;
        rd_req_ready = 1'b1;
        tick();
        rd_req_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            rd_data_valid = 1'b1;
            rd_data       = 32'h7700_0000 + 32'(b);
            tick();
        end
        chk("pre_reset_busy", 128'(miss_ready), 128'(0));
        rd_data = 32'h7700_0002;
        reset   = 1'b1;
        #1;
        check_reset_vals("async_rst");
        tick();
        reset = 1'b0;
        rd_data = 32'h7700_0003;
        rd_data_last = 1'b1;
        tick();
        rd_data_valid = 1'b0;
        rd_data_last  = 1'b0;
        tick();
        chk("trail_dropped_ready", 128'(miss_ready), 128'(1'b1));
        chk("trail_dropped_line", ram_wdata, 128'(0));
        chk("trail_no_req", 128'(rd_req_valid), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(32'h0000_1234, 32'h0000_00A0, 4, 0, 0, 1'b1, 1'b0, 32'h0000_00A1, 6'h23);
        vecs[1] = mk(32'h0000_20F0, 32'h0000_00B0, 4, 5, 2, 1'b1, 1'b0, 32'h0000_00B0, 6'h0F);
        vecs[2] = mk(32'h0000_3004, 32'h0000_00C0, 2, 0, 0, 1'b0, 1'b1, 32'h0000_00C1, 6'h00);
        vecs[3] = mk(32'h0000_400C, 32'h0000_00D0, 6, 1, 1, 1'b0, 1'b1, 32'h0000_00D3, 6'h00);
        vecs[4] = mk(32'hDEAD_BEEC, 32'h0000_00E0, 4, 2, 0, 1'b1, 1'b0, 32'h0000_00E3, 6'h2E);
        vecs[5] = mk(32'h0000_0040, 32'h1000_0040, 4, 0, 0, 1'b1, 1'b0, 32'h1000_0040, 6'h04);
        vecs[6] = mk(32'h0000_0080, 32'h2000_0080, 4, 0, 1, 1'b1, 1'b0, 32'h2000_0080, 6'h08);

        reset         = 1'b1;
        miss_valid    = 1'b0;
        miss_addr     = 32'h0;
        rd_req_ready  = 1'b0;
        rd_data_valid = 1'b0;
        rd_data       = 32'h0;
        rd_data_last  = 1'b0;
        tick();
        tick();
        check_reset_vals("reset");
        reset = 1'b0;

        // Beats arriving while idle must be dropped
        rd_data_valid = 1'b1;
        rd_data       = 32'hBAD0_BAD0;
        rd_data_last  = 1'b1;
        rd_req_ready  = 1'b1;
        tick();
        tick();
        rd_data_valid = 1'b0;
        rd_data_last  = 1'b0;
        rd_req_ready  = 1'b0;
        chk("idle_beat_drop_line", ram_wdata, 128'(0));
        chk("idle_beat_drop_ready", 128'(miss_ready), 128'(1'b1));

        for (int i = 0; i < 7; i++) begin
            if (i == 4) reset_mid_fill();
            run_vec(vecs[i]);
        end

        tick();
        chk("final_wr_queue", 128'(exp_wr.size()), 128'(0));
        chk("final_rsp_queue", 128'(exp_rsp.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
